// File: rtl/ahb_pkg.sv
// Shared types for the AHB-Lite command master: transfer encodings, the
// controller state names, the queued command record and an alignment helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_DATA = 3'd2,
        ST_DATA      = 3'd3,
        ST_ERR       = 3'd4
    } mst_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
    } cmd_t;

    // True when the size is legal and the address is a multiple of 2^size.
    function automatic logic cmd_aligned(input logic [31:0] addr, input logic [2:0] size);
        logic ok;
        case (size)
            HSIZE_BYTE:  ok = 1'b1;
            HSIZE_HALF:  ok = (addr[0] == 1'b0);
            HSIZE_WORD:  ok = (addr[1:0] == 2'b00);
            HSIZE_DWORD: ok = (addr[2:0] == 3'b000);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read. A pop on a full
// FIFO frees the slot for a push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(32'd1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == {(AW+1){1'b0}});
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array; contents need no reset because the count guards reads.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite master turning a valid/ready command stream into single pipelined
// transfers. The address phase is presented straight from the FIFO head and
// the head is only popped once the slave accepts it, so a command whose
// address phase is cancelled by an error response simply stays queued.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [63:0] rsp_rdata,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [63:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [63:0] HRDATA
);

    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    // Encodings: r_dstate only ever holds IDLE, DATA or ERR (the data side);
    // the ADDR flavours are derived from whether an address phase is shown.
    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_ADDR      = ST_ADDR;
    localparam logic [2:0] S_ADDR_DATA = ST_ADDR_DATA;
    localparam logic [2:0] S_DATA      = ST_DATA;
    localparam logic [2:0] S_ERR       = ST_ERR;

    cmd_t            w_cmd_in;
    cmd_t            w_head;
    logic            w_full;
    logic            w_empty;
    logic [CNTW-1:0] w_count;
    logic            w_push;
    logic            w_pop;
    logic            w_head_ok;
    logic            w_addr_phase;
    logic            w_accept;
    logic            w_mis_pop;
    logic [2:0]      w_state;
    logic [2:0]      w_dstate_nxt;
    logic            w_rsp_valid_nxt;
    logic            w_rsp_err_nxt;
    logic [63:0]     w_rsp_rdata_nxt;

    logic [2:0]      r_dstate;
    logic            r_dp_write;
    logic [63:0]     r_hwdata;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [63:0]     r_rsp_rdata;

    assign w_cmd_in = '{write: cmd_write, addr: cmd_addr, size: cmd_size, wdata: cmd_wdata};

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_push  (w_push),
        .i_wdata (w_cmd_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign cmd_ready    = (w_count < CNT_FULL);
    assign w_push       = cmd_valid & ~w_full;
    assign w_head_ok    = ~w_empty & cmd_aligned(w_head.addr, w_head.size);
    // No new address phase during the second error cycle: that is what
    // cancels the queued transfer after the first error cycle.
    assign w_addr_phase = w_head_ok & (r_dstate != S_ERR);
    assign w_accept     = w_addr_phase & HREADY;
    // Illegal commands are retired only with no data phase outstanding so
    // their error response cannot overtake an earlier transfer.
    assign w_mis_pop    = ~w_empty & ~cmd_aligned(w_head.addr, w_head.size) & (r_dstate == S_IDLE);
    assign w_pop        = w_accept | w_mis_pop;

    // Full controller state as seen on the bus this cycle.
    always_comb begin
        w_state = S_IDLE;
        if (r_dstate == S_ERR) begin
            w_state = S_ERR;
        end else if (w_addr_phase) begin
            w_state = (r_dstate == S_DATA) ? S_ADDR_DATA : S_ADDR;
        end else begin
            w_state = (r_dstate == S_DATA) ? S_DATA : S_IDLE;
        end
    end

    assign HTRANS = ((w_state == S_ADDR) || (w_state == S_ADDR_DATA)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSEL   = w_addr_phase;
    assign HADDR  = w_addr_phase ? w_head.addr  : 32'h0000_0000;
    assign HWRITE = w_addr_phase ? w_head.write : 1'b0;
    assign HSIZE  = w_addr_phase ? w_head.size  : 3'b000;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_VAL;
    assign HWDATA = r_hwdata;

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // Data-side next state and the response produced by this cycle.
    always_comb begin
        w_dstate_nxt    = r_dstate;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 64'h0;
        case (r_dstate)
            S_IDLE: begin
                if (w_accept) begin
                    w_dstate_nxt = S_DATA;
                end else if (w_mis_pop) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_dstate_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = HRESP;
                    if (!HRESP && !r_dp_write) begin
                        w_rsp_rdata_nxt = HRDATA;
                    end else begin
                        w_rsp_rdata_nxt = 64'h0;
                    end
                    if (w_accept) begin
                        w_dstate_nxt = S_DATA;
                    end else begin
                        w_dstate_nxt = S_IDLE;
                    end
                end else if (HRESP) begin
                    w_dstate_nxt = S_ERR;
                end else begin
                    w_dstate_nxt = S_DATA;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_dstate_nxt    = S_IDLE;
                end else begin
                    w_dstate_nxt = S_ERR;
                end
            end
            default: begin
                w_dstate_nxt = S_IDLE;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dstate    <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 64'h0;
        end else begin
            r_dstate    <= w_dstate_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    // Data-phase attributes captured when the address phase is accepted.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hwdata   <= 64'h0;
            r_dp_write <= 1'b0;
        end else if (w_accept) begin
            r_hwdata   <= w_head.wdata;
            r_dp_write <= w_head.write;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small AHB slave model and a
// response scoreboard.
module tb_ahb_lite_master;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [63:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        HSEL, HWRITE, HREADY, HRESP;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA, HRDATA;

    ahb_lite_master #(.FIFO_DEPTH(2), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc[$];
    logic [31:0] acc_addr[$];
    int          rsp_cyc[$];

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model: zero-wait memory unless the bench drives HREADY/HRESP.
    logic [63:0] mem [64];
    logic        sl_dv, sl_dw;
    logic [31:0] sl_da;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sl_dv <= 1'b0;
            sl_dw <= 1'b0;
            sl_da <= 32'h0;
            for (int i = 0; i < 64; i++) mem[i] <= pat(32'(i * 8));
        end else if (HREADY) begin
            if (sl_dv && sl_dw && !HRESP) mem[sl_da[8:3]] <= HWDATA;
            sl_dv <= (HTRANS == 2'b10);
            sl_dw <= HWRITE;
            sl_da <= HADDR;
        end
    end
    assign HRDATA = (sl_dv && !sl_dw) ? mem[sl_da[8:3]] : 64'h0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Bus/response monitor and scoreboard comparison.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (HTRANS == 2'b10 && HREADY) begin
                acc_cyc.push_back(cyc);
                acc_addr.push_back(HADDR);
            end
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                chk("rsp_expected", {63'd0, sb_q.size() != 0}, 64'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e.err});
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                end
            end
        end
    end

    task automatic clear_logs();
        acc_cyc.delete();
        acc_addr.delete();
        rsp_cyc.delete();
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, input logic e_err, input logic [63:0] e_rd,
                        input logic expect_rsp);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
        while (!cmd_ready && n < 100) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk("send_ready", {63'd0, n < 100}, 64'd1);
        if (expect_rsp) sb_q.push_back('{e_err, e_rd});
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
        @(posedge HCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 64'h0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hsel", 64'(HSEL), 64'd0);
        chk("rst_hwdata", HWDATA, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("hburst", 64'(HBURST), 64'd0);
        chk("hprot", 64'(HPROT), 64'd3);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Write then read back, with first-transfer latency.
        clear_logs();
        send(1'b1, 32'h0, 3'd3, 64'h1122334455667788, 1'b0, 64'h0, 1'b1);
        chk("wr_htrans", 64'(HTRANS), 64'h2);
        chk("wr_haddr", 64'(HADDR), 64'h0);
        chk("wr_hwrite", 64'(HWRITE), 64'd1);
        chk("wr_hsize", 64'(HSIZE), 64'd3);
        @(posedge HCLK); #1;
        chk("wr_hwdata", HWDATA, 64'h1122334455667788);
        drain();
        clear_logs();
        send(1'b0, 32'h0, 3'd3, 64'h0, 1'b0, 64'h1122334455667788, 1'b1);
        drain();
        chk("rd_counts", 64'(acc_cyc.size() + rsp_cyc.size()), 64'd2);
        if (acc_cyc.size() == 1 && rsp_cyc.size() == 1)
            chk("rd_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'd2);

        // Four back-to-back reads.
        clear_logs();
        for (int i = 0; i < 4; i++)
            send(1'b0, 32'(i * 8), 3'd3, 64'h0, 1'b0,
                 (i == 0) ? 64'h1122334455667788 : pat(32'(i * 8)), 1'b1);
        drain();
        chk("b2b_counts", 64'(acc_addr.size() + rsp_cyc.size()), 64'd8);
        if (acc_addr.size() == 4 && rsp_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_addr", 64'(acc_addr[i]), 64'(i * 8));
                chk("b2b_nonseq_cycle", 64'(acc_cyc[i] - acc_cyc[0]), 64'(i));
                chk("b2b_rsp_cycle", 64'(rsp_cyc[i] - rsp_cyc[0]), 64'(i));
            end
        end

        // Address-phase stall.
        clear_logs();
        HREADY = 1'b0;
        send(1'b0, 32'h40, 3'd3, 64'h0, 1'b0, pat(32'h40), 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_htrans", 64'(HTRANS), 64'h2);
            chk("stall_haddr", 64'(HADDR), 64'h40);
            @(posedge HCLK); #1;
        end
        HREADY = 1'b1;
        drain();
        chk("stall_one_rsp", 64'(rsp_cyc.size()), 64'd1);

        // Two-cycle error response with a queued read.
        clear_logs();
        send(1'b0, 32'h100, 3'd3, 64'h0, 1'b1, 64'h0, 1'b1);
        send(1'b0, 32'h108, 3'd3, 64'h0, 1'b0, pat(32'h108), 1'b1);
        n = 0;
        while (!(sl_dv && sl_da == 32'h100) && n < 20) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk("err_dp_found", {63'd0, n < 20}, 64'd1);
        HRESP = 1'b1; HREADY = 1'b0;
        chk("err1_htrans", 64'(HTRANS), 64'h2);
        chk("err1_haddr", 64'(HADDR), 64'h108);
        @(posedge HCLK); #1;
        chk("err2_htrans", 64'(HTRANS), 64'h0);
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        HRESP = 1'b0;
        chk("err_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("err_rsp_err", 64'(rsp_err), 64'd1);
        drain();
        chk("err_acc_count", 64'(acc_addr.size()), 64'd2);
        if (acc_addr.size() == 2) chk("err_reissue_addr", 64'(acc_addr[1]), 64'h108);

        // Misaligned and illegal-size commands interleaved with good ones.
        clear_logs();
        send(1'b0, 32'h10, 3'd3, 64'h0, 1'b0, pat(32'h10), 1'b1);
        send(1'b0, 32'h6, 3'd2, 64'h0, 1'b1, 64'h0, 1'b1);
        send(1'b0, 32'h0, 3'd4, 64'h0, 1'b1, 64'h0, 1'b1);
        send(1'b0, 32'h18, 3'd3, 64'h0, 1'b0, pat(32'h18), 1'b1);
        drain();
        chk("mis_bus_xfers", 64'(acc_addr.size()), 64'd2);
        chk("mis_rsp_count", 64'(rsp_cyc.size()), 64'd4);

        // Reset during the data phase of a write.
        send(1'b1, 32'h20, 3'd3, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 64'h0, 1'b0);
        @(posedge HCLK); #1;
        chk("pre_rst_hwdata", HWDATA, 64'hCAFE_F00D_DEAD_BEEF);
        HRESETn = 1'b0;
        #1;
        chk("arst_htrans", 64'(HTRANS), 64'd0);
        chk("arst_haddr", 64'(HADDR), 64'd0);
        chk("arst_hwrite", 64'(HWRITE), 64'd0);
        chk("arst_hsize", 64'(HSIZE), 64'd0);
        chk("arst_hwdata", HWDATA, 64'd0);
        chk("arst_hsel", 64'(HSEL), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        clear_logs();
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (5) @(posedge HCLK);
        #1;
        chk("arst_no_rsp", 64'(rsp_cyc.size()), 64'd0);
        chk("arst_no_bus", 64'(acc_addr.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Upstream AHB-Lite master for the testbench memory slave. Converts a simple valid/ready command stream, one transfer per command, into pipelined single AHB-Lite transfers. It returns one response per command. It buffers commands in a small FIFO, overlaps the next address phase with the current data phase, honours HREADY wait states and handles the two-cycle HRESP error response.

## Interface
Parameters:
- FIFO_DEPTH, 2: command FIFO entries, power of two, ≥2.
- HPROT_VAL, 4'b0011: constant driven on HPROT.

Ports (one clock; reset is asynchronous and active-low):
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full (combinational from FIFO count).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  HSIZE encoding 0..3; 4..7 are illegal.
- cmd_wdata  in  64  write data, already lane-placed by caller.
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_err  out  1  transfer failed (HRESP or misalignment).
- rsp_rdata  out  64  captured HRDATA for reads; 0 for writes and errors.
- HSEL  out  1  high whenever HTRANS is not IDLE.
- HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  64  write data during data phase.
- HREADY  in  1  slave HREADYOUT, looped back.
- HRESP  in  1  slave error.
- HRDATA  in  64  read data.

## Operation
- FSM states:
  - IDLE: no address phase, no data phase.
  - ADDR: address phase on bus.
  - ADDR_DATA: address phase for N+1 on bus while N is in data phase.
  - DATA: data phase only, HTRANS=IDLE.
  - ERR: second error cycle.
- Issue: when the FIFO is non-empty and the state is IDLE or DATA-completing, the head is popped. HADDR=cmd_addr, HTRANS=NONSEQ(2'b10), HWRITE, HSIZE are driven from it.
- Address-phase hold: while HREADY=0, HADDR, HTRANS, HWRITE and HSIZE hold unchanged.
- Address acceptance: the address phase is accepted on the edge with HREADY=1. That command becomes the data phase; HWDATA is loaded from its cmd_wdata on that edge.
  - If the FIFO still has an entry, its address phase is presented in the same cycle (ADDR→ADDR_DATA, or stays ADDR_DATA).
  - Otherwise HTRANS=IDLE (→DATA).
- Data-phase completion: the data phase completes on an edge with HREADY=1 and HRESP=0. HRDATA is captured and rsp_valid pulses next cycle with rsp_err=0.
- Error:
  - First cycle of the error response, HRESP=1 and HREADY=0: HTRANS is forced IDLE next cycle and any pending address phase is cancelled. The cancelled command is retained at the FIFO head, not popped.
  - Second cycle, HRESP=1 and HREADY=1: rsp_valid=1, rsp_err=1, rsp_rdata=0. The FSM goes to ERR→IDLE, then reissues the cancelled command.
- Misalignment: a command with cmd_size>3, or cmd_addr not a multiple of 2^cmd_size, never reaches the bus. It is popped and produces rsp_valid with rsp_err=1 one cycle later, in order with other responses.
- Responses: strictly in command order, exactly one per accepted command.

## Timing
- Reset values: HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, HSEL=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, FSM=IDLE, FIFO empty, so cmd_ready=1.
- Command accepted at edge k: NONSEQ appears in the cycle after edge k, at the earliest.
- Zero-wait read:
  - NONSEQ in cycle c.
  - Data phase in cycle c+1.
  - rsp_valid in cycle c+2.
- Back-to-back: with a full FIFO and HREADY=1, one transfer completes per cycle.
- A slave holding HREADY=0 for the first cycle after IDLE only stretches the address phase.
- A simultaneous push and pop on a full FIFO is allowed; the pop frees the slot in the same cycle.
- Reset asserted mid-transfer: all outputs return to reset values immediately. FIFO contents and in-flight transfers are discarded with no response.

## Structure
- Shared package ahb_pkg:
  - htrans_e (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - hsize constants
  - FSM state enum
  - cmd_t struct {write, addr, size, wdata}
- Sub-module: sync_fifo, parameterised by width and depth, with push/pop/full/empty/count. It holds cmd_t.

## Test plan
- Reset, then write 64'h1122334455667788 to 0x0000_0000 (size 3) and read it back → HTRANS 2'b10 one cycle after acceptance; rsp_rdata=64'h1122334455667788, rsp_err=0.
- Four back-to-back reads to 0x0, 0x8, 0x10, 0x18 with HREADY=1 → NONSEQ on 4 consecutive cycles; 4 rsp_valid pulses on consecutive cycles, in order.
- Stall: slave holds HREADY=0 for 3 cycles during the address phase of 0x40 → HADDR stays 0x40 and HTRANS stays 2'b10 for all 3 cycles; one response.
- Error: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on a read of 0x100, with a read of 0x108 queued → HTRANS=IDLE in the second error cycle; rsp_err=1 for 0x100; 0x108 is reissued afterwards and completes with rsp_err=0.
- Misaligned: size 2 at 0x0000_0006 → no bus activity; rsp_valid with rsp_err=1.
- Reset asserted during the data phase of a write → all H* outputs go to 0 asynchronously; no rsp_valid; cmd_ready=1 after release.
